// File: rtl/slice_cascade_comparator.sv
// Serial magnitude comparator: folds per-slice g/e/l results, MSB slice first,
// into a word-level relation with early exit and illegal-encoding detection.
module slice_cascade_comparator #(
    parameter int SLICES = 4,
    parameter int IW     = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          slice_valid,
    input  logic          slice_g,
    input  logic          slice_e,
    input  logic          slice_l,
    output logic          slice_ready,
    output logic [IW-1:0] slice_idx,
    output logic          busy,
    output logic          done,
    output logic          gt,
    output logic          eq,
    output logic          lt,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [IW-1:0] IDX_TOP = IW'(SLICES - 1);

    state_t        state_reg, state_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic          gt_reg, gt_next;
    logic          eq_reg, eq_next;
    logic          lt_reg, lt_next;
    logic          err_reg, err_next;
    logic          done_reg, done_next;
    logic          busy_reg, busy_next;
    logic          ready_reg, ready_next;

    logic accept;
    logic legal;

    assign accept = slice_valid & ready_reg;
    // Exactly one of the three flags set.
    assign legal  = (slice_g ^ slice_e ^ slice_l) & ~(slice_g & slice_e & slice_l);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        gt_next    = gt_reg;
        eq_next    = eq_reg;
        lt_next    = lt_reg;
        err_next   = err_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = RUN;
                    idx_next   = IDX_TOP;
                    gt_next    = 1'b0;
                    eq_next    = 1'b0;
                    lt_next    = 1'b0;
                    err_next   = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    if (!legal) begin
                        err_next   = 1'b1;
                        gt_next    = 1'b0;
                        eq_next    = 1'b0;
                        lt_next    = 1'b0;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (slice_g) begin
                        gt_next    = 1'b1;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (slice_l) begin
                        lt_next    = 1'b1;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else if (idx_reg == '0) begin
                        eq_next    = 1'b1;
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg - 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Handshake/status flops track the state being entered so they line up with it.
        busy_next  = (state_next == RUN);
        ready_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= IDX_TOP;
            gt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
            lt_reg    <= 1'b0;
            err_reg   <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            gt_reg    <= gt_next;
            eq_reg    <= eq_next;
            lt_reg    <= lt_next;
            err_reg   <= err_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
            ready_reg <= ready_next;
        end
    end

    assign slice_ready = ready_reg;
    assign slice_idx   = idx_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign gt          = gt_reg;
    assign eq          = eq_reg;
    assign lt          = lt_reg;
    assign err         = err_reg;

endmodule

// File: tb/tb_slice_cascade_comparator.sv
// Directed plus randomized checks of slice_cascade_comparator against a word-level model.
module tb_slice_cascade_comparator;

    localparam int SLICES = 4;
    localparam int IW     = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic          slice_valid = 1'b0;
    logic          slice_g = 1'b0;
    logic          slice_e = 1'b0;
    logic          slice_l = 1'b0;
    logic          slice_ready;
    logic [IW-1:0] slice_idx;
    logic          busy, done, gt, eq, lt, err;

    int vectors = 0;
    int miscompares = 0;

    slice_cascade_comparator #(.SLICES(SLICES), .IW(IW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .slice_valid(slice_valid), .slice_g(slice_g), .slice_e(slice_e), .slice_l(slice_l),
        .slice_ready(slice_ready), .slice_idx(slice_idx), .busy(busy), .done(done),
        .gt(gt), .eq(eq), .lt(lt), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(slice_ready), 32'd0);
        chk({tag, "_idx"}, 32'(slice_idx), 32'(SLICES - 1));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_res"}, 32'({gt, eq, lt, err}), 32'd0);
    endtask

    // One full comparison of words a and b; bad_pos >= 0 replaces that slice with bad_code.
    task automatic do_compare(input logic [7:0] a, input logic [7:0] b, input int bad_pos,
                              input logic [2:0] bad_code, input int min_stall,
                              input int max_stall, input bit mid_start);
        int          stop_k;
        bit          exp_err;
        logic [3:0]  exp_res;
        logic [1:0]  sa, sb;
        logic [2:0]  code;
        int          stalls;

        // Reference: the first unequal (or corrupted) slice from the top decides.
        stop_k  = 0;
        exp_err = 1'b0;
        for (int k = SLICES - 1; k >= 0; k--) begin
            sa = a[2*k +: 2];
            sb = b[2*k +: 2];
            if (k == bad_pos) begin
                exp_err = 1'b1;
                stop_k  = k;
                break;
            end
            if (sa != sb) begin
                stop_k = k;
                break;
            end
        end
        if (exp_err) exp_res = 4'b0001;
        else         exp_res = {a > b, a == b, a < b, 1'b0};

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
        chk("run_cleared", 32'({gt, eq, lt, err}), 32'd0);

        for (int k = SLICES - 1; k >= stop_k; k--) begin
            stalls = $urandom_range(max_stall, min_stall);
            for (int s = 0; s < stalls; s++) begin
                start = mid_start;
                @(negedge clk);
                start = 1'b0;
                chk("stall_idx", 32'(slice_idx), 32'(k));
                chk("stall_busy", 32'(busy), 32'd1);
                chk("stall_done", 32'(done), 32'd0);
            end
            chk("slice_idx", 32'(slice_idx), 32'(k));
            chk("slice_ready", 32'(slice_ready), 32'd1);
            sa = a[2*k +: 2];
            sb = b[2*k +: 2];
            if (k == bad_pos) code = bad_code;
            else              code = {sa > sb, sa == sb, sa < sb};
            slice_valid = 1'b1;
            {slice_g, slice_e, slice_l} = code;
            @(negedge clk);
            slice_valid = 1'b0;
            {slice_g, slice_e, slice_l} = 3'b000;
        end

        chk("done_pulse", 32'(done), 32'd1);
        chk("done_result", 32'({gt, eq, lt, err}), 32'(exp_res));
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(slice_ready), 32'd0);
        chk("done_idx", 32'(slice_idx), 32'(stop_k));
        @(negedge clk);
        chk("after_done", 32'(done), 32'd0);
        chk("held_result", 32'({gt, eq, lt, err}), 32'(exp_res));
        @(negedge clk);
        chk("held_result2", 32'({gt, eq, lt, err}), 32'(exp_res));
        $display("compare a=%02h b=%02h bad_pos=%0d -> gt/eq/lt/err expected %b observed %b",
                 a, b, bad_pos, exp_res, {gt, eq, lt, err});
    endtask

    logic [2:0] illegal_codes [5];
    logic [7:0] ra, rb;
    int         rk, rbad;

    initial begin
        illegal_codes[0] = 3'b000;
        illegal_codes[1] = 3'b011;
        illegal_codes[2] = 3'b101;
        illegal_codes[3] = 3'b110;
        illegal_codes[4] = 3'b111;

        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("idle");

        do_compare(8'hB4, 8'hB4, -1, 3'b000, 0, 0, 1'b0);
        do_compare(8'hB4, 8'h74, -1, 3'b000, 0, 0, 1'b0);
        do_compare(8'hB1, 8'hB2, -1, 3'b000, 3, 3, 1'b0);
        do_compare(8'hB4, 8'hB4, 2, 3'b110, 0, 1, 1'b0);
        do_compare(8'h12, 8'h12, -1, 3'b000, 2, 2, 1'b1);
        do_compare(8'h00, 8'h01, -1, 3'b000, 0, 0, 1'b0);

        // Asynchronous reset in the middle of a comparison.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        slice_valid = 1'b1;
        {slice_g, slice_e, slice_l} = 3'b010;
        @(negedge clk);
        slice_valid = 1'b0;
        {slice_g, slice_e, slice_l} = 3'b000;
        chk("pre_reset_idx", 32'(slice_idx), 32'(SLICES - 2));
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async_reset");
        @(negedge clk);
        chk_reset_outputs("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("reset_release");
        do_compare(8'h9C, 8'h9D, -1, 3'b000, 0, 1, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = 8'($urandom);
            rb = ra;
            rk = $urandom_range(SLICES, 0);
            if (rk < SLICES) rb[2*rk +: 2] = 2'($urandom);
            rbad = ($urandom_range(4, 0) == 0) ? int'($urandom_range(SLICES - 1, 0)) : -1;
            do_compare(ra, rb, rbad, illegal_codes[$urandom_range(4, 0)], 0, 2, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slice_cascade_comparator.md
Name: slice_cascade_comparator

Overview:
Sequential downstream stage for the 2-bit comparator. Consumes one 2-bit slice result (g/e/l) per accepted handshake, MSB slice first, and resolves the magnitude relation of a 2*SLICES-bit word pair. One comparator instance is shared serially across all slices. Terminates early on the first unequal slice, flags illegal slice encodings, and holds the final result until the next start.

Parameters:
SLICES, 4, number of 2-bit slices per word; default 4 = 8-bit compare; legal range 2..16
IW, 4, width of slice_idx; must satisfy 2**IW >= SLICES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin a new comparison; sampled only in IDLE or DONE
slice_valid  input  1  slice_g/e/l are valid this cycle
slice_g  input  1  current slice: a > b
slice_e  input  1  current slice: a == b
slice_l  input  1  current slice: a < b
slice_ready  output  1  block accepts a slice this cycle
slice_idx  output  IW  index of the slice requested; SLICES-1 = MSB slice
busy  output  1  comparison in progress
done  output  1  one-cycle pulse: result valid
gt  output  1  word a > word b; held after done
eq  output  1  word a == word b; held after done
lt  output  1  word a < word b; held after done
err  output  1  illegal slice encoding seen; held after done

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; slice_ready=0; busy=0; done=0; gt=eq=lt=0; err=0; slice_idx=SLICES-1.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE: start=1 -> RUN next cycle. Also clears gt/eq/lt/err and sets slice_idx=SLICES-1.
- RUN: busy=1; slice_ready=1. A slice is accepted when slice_valid & slice_ready.
- Acceptance with legal encoding (exactly one of g/e/l high):
  - g: gt<=1, then DONE.
  - l: lt<=1, then DONE.
  - e with slice_idx==0: eq<=1, then DONE.
  - e with slice_idx>0: slice_idx decrements; remain in RUN.
- Acceptance with illegal encoding (zero or more than one of g/e/l high): err<=1, gt=eq=lt=0, then DONE.
- Cycles in RUN without slice_valid: hold state and slice_idx (unbounded stall allowed).
- DONE:
  - done=1 for exactly the first cycle in DONE.
  - busy=0; slice_ready=0.
  - gt/eq/lt/err hold their values.
  - start=1 in DONE: clear results and re-enter RUN next cycle. done must not reassert until the new comparison resolves.
- start while in RUN is ignored; no restart.
- Latency:
  - start sampled at edge N -> slice_ready=1 from cycle N+1.
  - Deciding slice accepted at edge M -> done=1 and results valid in cycle M+1.
  - Best case is 1 slice; worst case is SLICES slices.
- Exactly one of gt/eq/lt/err is high whenever done=1.
- slice_idx never underflows; it stays at 0 after the final slice is accepted.
- Reset asserted mid-RUN aborts immediately to reset values; no done pulse is produced.

Test Plan:
- SLICES=4, A=8'hB4, B=8'hB4 (slices e,e,e,e, valid every cycle) -> 4 acceptances; slice_idx 3,2,1,0; done one cycle after 4th acceptance; eq=1, gt=lt=err=0.
- A=8'hB4, B=8'h74 (MSB slice 2'b10 vs 2'b01 -> g) -> done after first acceptance; gt=1; slice_idx stays 3; remaining slices never requested.
- A=8'hB1, B=8'hB2 (slices e,e,e,l) with slice_valid low for 3 cycles before each slice -> stalls honoured; lt=1 after 4th acceptance; busy high throughout RUN.
- Illegal slice {g,e,l}=3'b110 on slice 2 after an equal MSB slice -> err=1, gt=eq=lt=0; done pulses once; results held until next start.
- start pulsed again mid-RUN -> ignored; then start in DONE -> results clear; new compare of 8'h00 vs 8'h01 yields lt=1.
- rst_n driven low asynchronously between clock edges mid-RUN -> all outputs return to reset values immediately, no done pulse; after release, start works normally.
